// File: rtl/om_pkg.sv
// ---------------------------------------------------------------------------
// om_pkg
// Shared types and constants for the output-merger blend arbiter slice.
//   om_color_t          : 32-bit RGBA color, four 8-bit channels.
//   OM_COLOR_W          : width of one packed color.
//   OM_NUM_REQS_DEF     : default number of requester lanes.
//   OM_MAX_PENDING_DEF  : default number of in-flight blend operations.
// ---------------------------------------------------------------------------
package om_pkg;

  localparam int OM_COLOR_W         = 32;
  localparam int OM_NUM_REQS_DEF    = 4;
  localparam int OM_MAX_PENDING_DEF = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } om_color_t;

endpackage

// File: rtl/om_rr_arbiter.sv
// ---------------------------------------------------------------------------
// om_rr_arbiter
// Round-robin picker: combinational grant searching upward from a registered
// pointer, which moves one past the winner whenever the grant is consumed.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (pointer -> 0)
//   req_valid_i    : per-lane request valid
//   advance_i      : the current grant was accepted this cycle
//   grant_valid_o  : at least one lane is requesting
//   grant_idx_o    : index of the winning lane (0 when none)
// ---------------------------------------------------------------------------
module om_rr_arbiter #(
  parameter int  NUM_REQS = 4,
  localparam int TAG_W    = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_valid_i,
  input  logic                advance_i,
  output logic                grant_valid_o,
  output logic [TAG_W-1:0]    grant_idx_o
);

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;

  // Walk the offsets from highest to lowest so the lane closest to the
  // pointer (smallest offset) overwrites all others and wins.
  always_comb begin
    int idx;
    idx           = 0;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end
      if (req_valid_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = TAG_W'(idx);
      end
    end
  end

  // Pointer moves one past the winner with an explicit wrap, since
  // NUM_REQS need not be a power of two.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (grant_idx_o == TAG_W'(NUM_REQS - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/om_blend_arbiter.sv
// ---------------------------------------------------------------------------
// om_blend_arbiter
// Shares one in-order blend pipeline between NUM_REQS lanes. A round-robin
// pick issues one src/dst pair per cycle; the winner's lane index is kept in
// an in-order tag FIFO so each blend result is steered back to its issuer.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : per-lane request handshake
//   req_src_color/req_dst_color     : per-lane colors, lane i at [32*i +: 32]
//   rsp_valid/rsp_ready             : per-lane result handshake
//   rsp_color                       : blended color shared by all lanes
//   blend_valid_in/ready_in,
//   blend_src_color/dst_color       : issue side of the blend unit
//   blend_valid_out/ready_out,
//   blend_color_out                 : result side of the blend unit
//   idle                            : nothing in flight and nothing requested
// MAX_PENDING must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module om_blend_arbiter
  import om_pkg::*;
#(
  parameter int  NUM_REQS    = OM_NUM_REQS_DEF,
  parameter int  MAX_PENDING = OM_MAX_PENDING_DEF,
  localparam int TAG_W       = $clog2(NUM_REQS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  output logic [NUM_REQS-1:0]            req_ready,
  input  logic [NUM_REQS*OM_COLOR_W-1:0] req_src_color,
  input  logic [NUM_REQS*OM_COLOR_W-1:0] req_dst_color,
  output logic [NUM_REQS-1:0]            rsp_valid,
  input  logic [NUM_REQS-1:0]            rsp_ready,
  output om_color_t                      rsp_color,
  output logic                           blend_valid_in,
  input  logic                           blend_ready_in,
  output om_color_t                      blend_src_color,
  output om_color_t                      blend_dst_color,
  input  logic                           blend_valid_out,
  output logic                           blend_ready_out,
  input  om_color_t                      blend_color_out,
  output logic                           idle
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [TAG_W-1:0] tag_mem_q [MAX_PENDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] pending_q, pending_d;

  logic             fifo_full, fifo_empty, any_valid, can_issue;
  logic             grant_valid, push, pop;
  logic [TAG_W-1:0] grant_idx, head;
  om_color_t        src_lane [NUM_REQS];
  om_color_t        dst_lane [NUM_REQS];

  assign fifo_full  = (pending_q == CNT_W'(MAX_PENDING));
  assign fifo_empty = (pending_q == '0);
  assign any_valid  = |req_valid;
  assign can_issue  = blend_ready_in & ~fifo_full;
  assign head       = tag_mem_q[rd_ptr_q];
  assign push       = blend_valid_in & blend_ready_in;
  assign pop        = blend_valid_out & blend_ready_out;
  assign rsp_color  = blend_color_out;
  assign idle       = reset | (fifo_empty & ~any_valid);

  om_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .advance_i     (push),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      src_lane[i] = req_src_color[i*OM_COLOR_W +: OM_COLOR_W];
      dst_lane[i] = req_dst_color[i*OM_COLOR_W +: OM_COLOR_W];
    end
  end

  // Issue side. Fullness alone blocks issue, so req_ready never depends on
  // rsp_ready through a same-cycle pop.
  always_comb begin
    req_ready       = '0;
    blend_valid_in  = any_valid & ~fifo_full & ~reset;
    blend_src_color = '0;
    blend_dst_color = '0;
    if (grant_valid) begin
      blend_src_color      = src_lane[grant_idx];
      blend_dst_color      = dst_lane[grant_idx];
      req_ready[grant_idx] = can_issue & ~reset;
    end
  end

  // Return side. A result arriving with no outstanding tag is never accepted.
  always_comb begin
    rsp_valid       = '0;
    blend_ready_out = 1'b0;
    if (!fifo_empty && !reset) begin
      rsp_valid[head] = blend_valid_out;
      blend_ready_out = rsp_ready[head];
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (push && !pop) begin
      pending_d = pending_q + 1'b1;
    end else if (!push && pop) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      pending_q <= pending_d;
    end
  end

  // Tag storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  a_no_orphan_result : assert property (
    @(posedge clk) disable iff (reset) !(blend_valid_out && fifo_empty)
  );

endmodule

// File: tb/tb_om_blend_arbiter.sv
// ---------------------------------------------------------------------------
// tb_om_blend_arbiter
// Directed bench for om_blend_arbiter with a pass-through (ONE/ZERO) blend
// unit model: every issued src color comes back unchanged, in order.
// ---------------------------------------------------------------------------
module tb_om_blend_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    reqValid, reqReady, rspValid, rspReady;
  logic [N*32-1:0] reqSrc, reqDst;
  logic [31:0]     rspColor, blendSrc, blendDst, blendColorOut;
  logic            blendValidIn, blendReadyIn, blendValidOut, blendReadyOut;
  logic            idleFlag;

  int          vecCount  = 0;
  int          missCount = 0;
  logic        outEn     = 1'b0;
  int          qCount    = 0;
  logic [31:0] bq [$];
  int          grantLog [$];
  int          rxLane [$];
  logic [31:0] rxColor [$];

  always #5 clk = ~clk;

  assign blendValidOut = outEn && (qCount > 0);

  om_blend_arbiter #(
    .NUM_REQS    (N),
    .MAX_PENDING (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (reqValid),
    .req_ready       (reqReady),
    .req_src_color   (reqSrc),
    .req_dst_color   (reqDst),
    .rsp_valid       (rspValid),
    .rsp_ready       (rspReady),
    .rsp_color       (rspColor),
    .blend_valid_in  (blendValidIn),
    .blend_ready_in  (blendReadyIn),
    .blend_src_color (blendSrc),
    .blend_dst_color (blendDst),
    .blend_valid_out (blendValidOut),
    .blend_ready_out (blendReadyOut),
    .blend_color_out (blendColorOut),
    .idle            (idleFlag)
  );

  // Pass-through blend unit: handshakes sampled at the edge, state updated
  // just after it so the DUT never races against the model.
  always @(posedge clk) begin : blendModel
    logic        pushNow, popNow, rstNow;
    logic [31:0] pushData;
    pushNow  = blendValidIn && blendReadyIn;
    popNow   = blendValidOut && blendReadyOut;
    rstNow   = reset;
    pushData = blendSrc;
    #1;
    if (rstNow) begin
      bq.delete();
    end else begin
      if (popNow) void'(bq.pop_front());
      if (pushNow) bq.push_back(pushData);
    end
    qCount        = bq.size();
    blendColorOut = (bq.size() > 0) ? bq[0] : 32'h0;
  end

  // Log every accepted request and every delivered result per lane.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reqValid[i] && reqReady[i]) grantLog.push_back(i);
      if (rspValid[i] && rspReady[i]) begin
        rxLane.push_back(i);
        rxColor.push_back(rspColor);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    reqValid = '0;
    @(negedge clk);
    reset = 1'b0;
    grantLog.delete();
    rxLane.delete();
    rxColor.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reqValid = '1;
    #1;
    vecCount++;
    if (reqReady !== 4'b0000) begin missCount++; $display("[TB] FAIL reset_req_ready: got %b want 0000", reqReady); end
    vecCount++;
    if (rspValid !== 4'b0000) begin missCount++; $display("[TB] FAIL reset_rsp_valid: got %b want 0000", rspValid); end
    vecCount++;
    if (blendValidIn !== 1'b0) begin missCount++; $display("[TB] FAIL reset_blend_valid_in: got %b want 0", blendValidIn); end
    vecCount++;
    if (blendReadyOut !== 1'b0) begin missCount++; $display("[TB] FAIL reset_blend_ready_out: got %b want 0", blendReadyOut); end
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL reset_idle: got %b want 1", idleFlag); end
    reqValid = '0;
  endtask

  task automatic test_single_lane();
    doReset();
    outEn            = 1'b1;
    rspReady         = '1;
    reqSrc[64 +: 32] = 32'hb4ef4b7b;
    reqDst[64 +: 32] = 32'hc2c426f5;
    reqValid         = 4'b0100;
    #1;
    vecCount++;
    if (reqReady !== 4'b0100) begin missCount++; $display("[TB] FAIL single_req_ready: got %b want 0100", reqReady); end
    vecCount++;
    if (blendValidIn !== 1'b1) begin missCount++; $display("[TB] FAIL single_blend_valid_in: got %b want 1", blendValidIn); end
    vecCount++;
    if (blendSrc !== 32'hb4ef4b7b) begin missCount++; $display("[TB] FAIL single_src: got %h want b4ef4b7b", blendSrc); end
    vecCount++;
    if (blendDst !== 32'hc2c426f5) begin missCount++; $display("[TB] FAIL single_dst: got %h want c2c426f5", blendDst); end
    @(negedge clk);
    reqValid = '0;
    #1;
    vecCount++;
    if (rspValid !== 4'b0100) begin missCount++; $display("[TB] FAIL single_rsp_valid: got %b want 0100", rspValid); end
    vecCount++;
    if (rspColor !== 32'hb4ef4b7b) begin missCount++; $display("[TB] FAIL single_rsp_color: got %h want b4ef4b7b", rspColor); end
    vecCount++;
    if (idleFlag !== 1'b0) begin missCount++; $display("[TB] FAIL single_busy: got %b want 0", idleFlag); end
    @(negedge clk);
    #1;
    vecCount++;
    if (rspValid !== 4'b0000) begin missCount++; $display("[TB] FAIL single_rsp_done: got %b want 0000", rspValid); end
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL single_idle: got %b want 1", idleFlag); end
    vecCount++;
    if (rxLane.size() !== 1) begin missCount++; $display("[TB] FAIL single_rx_count: got %0d want 1", rxLane.size()); end
  endtask

  task automatic test_round_robin();
    int expOrder [6] = '{0, 1, 2, 3, 0, 1};
    doReset();
    outEn    = 1'b1;
    rspReady = '1;
    for (int i = 0; i < N; i++) begin
      reqSrc[i*32 +: 32] = 32'h11223300 + 32'(i);
      reqDst[i*32 +: 32] = 32'h0;
    end
    reqValid = '1;
    repeat (6) @(negedge clk);
    reqValid = '0;
    for (int c = 0; c < 40 && rxLane.size() < 6; c++) @(negedge clk);
    vecCount++;
    if (grantLog.size() !== 6) begin missCount++; $display("[TB] FAIL rr_grant_count: got %0d want 6", grantLog.size()); end
    vecCount++;
    if (rxLane.size() !== 6) begin missCount++; $display("[TB] FAIL rr_rx_count: got %0d want 6", rxLane.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < grantLog.size()) begin
        vecCount++;
        if (grantLog[k] !== expOrder[k]) begin missCount++; $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", k, grantLog[k], expOrder[k]); end
      end
      if (k < rxLane.size()) begin
        vecCount++;
        if (rxLane[k] !== expOrder[k]) begin missCount++; $display("[TB] FAIL rr_rx_lane[%0d]: got %0d want %0d", k, rxLane[k], expOrder[k]); end
        vecCount++;
        if (rxColor[k] !== 32'h11223300 + 32'(expOrder[k])) begin missCount++; $display("[TB] FAIL rr_rx_color[%0d]: got %h want %h", k, rxColor[k], 32'h11223300 + 32'(expOrder[k])); end
      end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    outEn    = 1'b1;
    rspReady = '0;
    reqValid = '1;
    repeat (10) @(negedge clk);
    #1;
    vecCount++;
    if (grantLog.size() !== 8) begin missCount++; $display("[TB] FAIL bp_accepted: got %0d want 8", grantLog.size()); end
    vecCount++;
    if (reqReady !== 4'b0000) begin missCount++; $display("[TB] FAIL bp_req_ready_full: got %b want 0000", reqReady); end
    vecCount++;
    if (blendValidIn !== 1'b0) begin missCount++; $display("[TB] FAIL bp_valid_in_full: got %b want 0", blendValidIn); end
    vecCount++;
    if (rxLane.size() !== 0) begin missCount++; $display("[TB] FAIL bp_no_rx: got %0d want 0", rxLane.size()); end
    reqValid = '0;
    rspReady = '1;
    for (int c = 0; c < 40 && rxLane.size() < 8; c++) @(negedge clk);
    vecCount++;
    if (rxLane.size() !== 8) begin missCount++; $display("[TB] FAIL bp_rx_count: got %0d want 8", rxLane.size()); end
    for (int k = 0; k < 8 && k < rxLane.size(); k++) begin
      vecCount++;
      if (rxLane[k] !== k % 4) begin missCount++; $display("[TB] FAIL bp_rx_lane[%0d]: got %0d want %0d", k, rxLane[k], k % 4); end
      vecCount++;
      if (rxColor[k] !== 32'h11223300 + 32'(k % 4)) begin missCount++; $display("[TB] FAIL bp_rx_color[%0d]: got %h want %h", k, rxColor[k], 32'h11223300 + 32'(k % 4)); end
    end
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL bp_idle_after_drain: got %b want 1", idleFlag); end
    reqValid = 4'b0010;
    #1;
    vecCount++;
    if (reqReady !== 4'b0010) begin missCount++; $display("[TB] FAIL bp_resume_ready: got %b want 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    for (int c = 0; c < 20 && rxLane.size() < 9; c++) @(negedge clk);
    vecCount++;
    if (rxLane.size() !== 9) begin missCount++; $display("[TB] FAIL bp_resume_rx: got %0d want 9", rxLane.size()); end
  endtask

  task automatic test_push_pop();
    doReset();
    outEn    = 1'b0;
    rspReady = '1;
    reqValid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      reqSrc[31:0] = 32'hAA000000 + 32'(grantLog.size());
      @(negedge clk);
    end
    reqSrc[31:0] = 32'hAA000000 + 32'(grantLog.size());
    outEn        = 1'b1;
    #1;
    vecCount++;
    if (reqReady !== 4'b0001) begin missCount++; $display("[TB] FAIL pp_push: got %b want 0001", reqReady); end
    vecCount++;
    if (blendReadyOut !== 1'b1) begin missCount++; $display("[TB] FAIL pp_pop: got %b want 1", blendReadyOut); end
    @(negedge clk);
    outEn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      reqSrc[31:0] = 32'hAA000000 + 32'(grantLog.size());
      @(negedge clk);
    end
    #1;
    vecCount++;
    if (grantLog.size() !== 9) begin missCount++; $display("[TB] FAIL pp_grants_to_full: got %0d want 9", grantLog.size()); end
    vecCount++;
    if (reqReady !== 4'b0000) begin missCount++; $display("[TB] FAIL pp_full_ready: got %b want 0000", reqReady); end
    vecCount++;
    if (rxLane.size() !== 1) begin missCount++; $display("[TB] FAIL pp_rx_before_drain: got %0d want 1", rxLane.size()); end
    reqValid = '0;
    outEn    = 1'b1;
    for (int c = 0; c < 40 && rxLane.size() < 9; c++) @(negedge clk);
    vecCount++;
    if (rxLane.size() !== 9) begin missCount++; $display("[TB] FAIL pp_rx_count: got %0d want 9", rxLane.size()); end
    for (int k = 0; k < 9 && k < rxColor.size(); k++) begin
      vecCount++;
      if (rxColor[k] !== 32'hAA000000 + 32'(k)) begin missCount++; $display("[TB] FAIL pp_order[%0d]: got %h want %h", k, rxColor[k], 32'hAA000000 + 32'(k)); end
    end
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL pp_idle: got %b want 1", idleFlag); end
  endtask

  task automatic test_back_to_back_stall();
    doReset();
    outEn        = 1'b1;
    rspReady     = '1;
    blendReadyIn = 1'b0;
    reqValid     = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      vecCount++;
      if (reqReady !== 4'b0000) begin missCount++; $display("[TB] FAIL stall_ready[%0d]: got %b want 0000", k, reqReady); end
      vecCount++;
      if (blendValidIn !== 1'b1) begin missCount++; $display("[TB] FAIL stall_valid_in[%0d]: got %b want 1", k, blendValidIn); end
      @(negedge clk);
    end
    blendReadyIn = 1'b1;
    #1;
    vecCount++;
    if (reqReady !== 4'b0010) begin missCount++; $display("[TB] FAIL stall_first_lane1: got %b want 0010", reqReady); end
    @(negedge clk);
    #1;
    vecCount++;
    if (reqReady !== 4'b1000) begin missCount++; $display("[TB] FAIL stall_next_lane3: got %b want 1000", reqReady); end
    @(negedge clk);
    reqValid = '0;
    for (int c = 0; c < 20 && rxLane.size() < 2; c++) @(negedge clk);
    vecCount++;
    if (grantLog.size() !== 2) begin missCount++; $display("[TB] FAIL stall_grant_count: got %0d want 2", grantLog.size()); end
    vecCount++;
    if (rxLane.size() !== 2) begin missCount++; $display("[TB] FAIL stall_rx_count: got %0d want 2", rxLane.size()); end
    if (rxLane.size() == 2) begin
      vecCount++;
      if (rxLane[0] !== 1 || rxLane[1] !== 3) begin missCount++; $display("[TB] FAIL stall_rx_lanes: got %0d,%0d want 1,3", rxLane[0], rxLane[1]); end
    end
  endtask

  task automatic test_reset_midop();
    doReset();
    outEn    = 1'b0;
    rspReady = '1;
    reqValid = '1;
    repeat (5) @(negedge clk);
    #1;
    vecCount++;
    if (grantLog.size() !== 5) begin missCount++; $display("[TB] FAIL mid_pending5: got %0d want 5", grantLog.size()); end
    vecCount++;
    if (idleFlag !== 1'b0) begin missCount++; $display("[TB] FAIL mid_busy: got %b want 0", idleFlag); end
    reset    = 1'b1;
    reqValid = '0;
    outEn    = 1'b1;
    #1;
    vecCount++;
    if (blendReadyOut !== 1'b0 || rspValid !== 4'b0000) begin missCount++; $display("[TB] FAIL mid_in_reset: got ready_out=%b rsp_valid=%b want 0 0000", blendReadyOut, rspValid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL mid_idle_after: got %b want 1", idleFlag); end
    vecCount++;
    if (rspValid !== 4'b0000) begin missCount++; $display("[TB] FAIL mid_rsp_after: got %b want 0000", rspValid); end
    rxLane.delete();
    rxColor.delete();
    reqSrc[31:0] = 32'h0BADF00D;
    reqValid     = 4'b0001;
    #1;
    vecCount++;
    if (reqReady !== 4'b0001) begin missCount++; $display("[TB] FAIL mid_new_ready: got %b want 0001", reqReady); end
    @(negedge clk);
    reqValid = '0;
    for (int c = 0; c < 20 && rxLane.size() < 1; c++) @(negedge clk);
    vecCount++;
    if (rxLane.size() !== 1) begin missCount++; $display("[TB] FAIL mid_new_rx_count: got %0d want 1", rxLane.size()); end
    if (rxLane.size() == 1) begin
      vecCount++;
      if (rxLane[0] !== 0 || rxColor[0] !== 32'h0BADF00D) begin missCount++; $display("[TB] FAIL mid_new_rx: got lane %0d color %h want lane 0 color 0badf00d", rxLane[0], rxColor[0]); end
    end
    vecCount++;
    if (idleFlag !== 1'b1) begin missCount++; $display("[TB] FAIL mid_final_idle: got %b want 1", idleFlag); end
  endtask

  initial begin
    reset         = 1'b1;
    reqValid      = '0;
    rspReady      = '0;
    reqSrc        = '0;
    reqDst        = '0;
    blendReadyIn  = 1'b1;
    blendColorOut = 32'h0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_back_to_back_stall();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/om_blend_arbiter.md
Name: om_blend_arbiter

Overview:
- Shares one VX_om_blend pipeline between NUM_REQS requester lanes (output-merger quads/cores).
- Round-robin arbitration picks one src/dst color pair per cycle and issues it to the blend unit.
- Records the winner's index in an in-order tag FIFO and steers each blend result back to the lane that issued it.
- Provides an idle flag so the DCR block only changes blend state (dcrs) while the shared pipeline is empty.

Parameters:
- NUM_REQS, 4, number of requester lanes (2..16).
- MAX_PENDING, 8, maximum in-flight blend operations; depth of the tag FIFO (power of two).
- TAG_W, $clog2(NUM_REQS), width of the lane index (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-lane request valid.
- req_ready  out  NUM_REQS  per-lane request accept.
- req_src_color  in  NUM_REQS*32  per-lane source color (om_color_t).
- req_dst_color  in  NUM_REQS*32  per-lane destination color (om_color_t).
- rsp_valid  out  NUM_REQS  per-lane result valid.
- rsp_ready  in  NUM_REQS  per-lane result accept.
- rsp_color  out  32  blended color, shared by all lanes; qualified by rsp_valid.
- blend_valid_in  out  1  to blend unit valid_in.
- blend_ready_in  in  1  from blend unit ready_in.
- blend_src_color  out  32  to blend unit src_color.
- blend_dst_color  out  32  to blend unit dst_color.
- blend_valid_out  in  1  from blend unit valid_out.
- blend_ready_out  out  1  to blend unit ready_out.
- blend_color_out  in  32  from blend unit color_out.
- idle  out  1  high when pending==0 and no req_valid is asserted.

Behaviour:
- Reset: rr_ptr=0, tag FIFO empty, pending=0. During reset all req_ready, rsp_valid, blend_valid_in and blend_ready_out are 0; idle=1.
- Issue, combinational with zero added latency:
  - can_issue = blend_ready_in & ~fifo_full.
  - winner = first lane with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQS.
  - blend_valid_in = any req_valid & ~fifo_full.
  - blend_src_color / blend_dst_color = winner's colors; 0 when no lane is valid.
  - req_ready[winner] = can_issue; all other req_ready are 0.
- Issue fire (blend_valid_in & blend_ready_in): push winner tag; rr_ptr <= (winner+1) mod NUM_REQS. rr_ptr holds when nothing fires.
- Return path:
  - head = FIFO head tag.
  - rsp_valid[head] = blend_valid_out & ~fifo_empty; all other rsp_valid are 0.
  - rsp_color = blend_color_out.
  - blend_ready_out = rsp_ready[head] & ~fifo_empty.
- Return fire: pop the FIFO.
- pending counter (0..MAX_PENDING): +1 on push, -1 on pop, unchanged when push and pop occur in the same cycle.
- fifo_full = (pending==MAX_PENDING). When full, issue is blocked even if a pop occurs that cycle; this keeps req_ready independent of rsp_ready.
- Ordering: the blend unit is in-order, so results return in issue order. A lane never receives another lane's result.
- Fairness: with all lanes continuously valid, grants rotate 0,1,2,...,NUM_REQS-1,0. The worst-case wait per lane is NUM_REQS-1 grants.
- A stalled lane (rsp_ready=0 at head) blocks all returns (head-of-line). This is accepted; issue continues until the FIFO is full.
- Error condition: blend_valid_out while fifo_empty must never occur. A simulation assertion fires, and the result is dropped (blend_ready_out=0).
- idle is registered-free, derived from pending and req_valid. The DCR writer must see idle=1 before changing dcrs.
- Reset mid-operation: FIFO and counter clear next cycle. In-flight blend results are discarded because the blend unit is reset by the same signal.

Decomposition:
- om_pkg:
  - om_color_t (32-bit RGBA, 4x8).
  - Arbiter constants: default NUM_REQS and MAX_PENDING.
- Sub-modules:
  - Tag FIFO: reuse the existing generic fifo primitive (VX_fifo_queue, DATAW=TAG_W, DEPTH=MAX_PENDING).
  - Round-robin pick: natural sub-module om_rr_arbiter (NUM_REQS, combinational grant plus registered pointer).

Test Plan:
- Single lane: lane 2 issues src=b4ef4b7b dst=c2c426f5, blend set ONE/ZERO -> rsp_valid=0100, rsp_color=b4ef4b7b, all other rsp_valid=0.
- All 4 lanes continuously valid, blend_ready_in=1 -> grant order 0,1,2,3,0,1; each lane's result carries its own src color (lane id encoded in the src color byte).
- Backpressure: hold rsp_ready=0 for all lanes, issue 10 requests -> exactly 8 accepted; req_ready=0 thereafter and pending=8. Release rsp_ready -> 8 results return in issue order, then issue resumes.
- Simultaneous push/pop at pending=3 -> pending stays 3; FIFO contents are ordered correctly on drain.
- blend_ready_in=0 for 5 cycles with lanes 1 and 3 valid -> no req_ready and rr_ptr unchanged. Then lane 1 is granted first (rr_ptr=0), lane 3 next.
- Reset asserted with pending=5 -> next cycle pending=0, idle=1, no rsp_valid; a subsequent request from lane 0 completes normally.
